// File: rtl/capture_ctrl.sv
// capture_ctrl: trigger-based capture controller in front of a single-port BRAM.
// Records a pre-trigger ring plus post-trigger samples, then streams them out oldest-first.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   arm                 start a capture (from IDLE/DONE)
//   trig_in, force_trig hardware trigger (qualified by s_valid), sticky software trigger
//   post_len            post-trigger sample count, sampled on arm
//   rd_start            start readout (from DONE)
//   s_data, s_valid     input sample stream, no backpressure
//   m_data, m_valid,
//   m_ready             readout stream
//   state               FSM state code
//   trig_addr, wrapped  capture status
//   bram_*              BRAM port (registered we/re/addr/wdata; rdata/valid returned)
module capture_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  trig_in,
  input  logic                  force_trig,
  input  logic [ADDR_WIDTH-1:0] post_len,
  input  logic                  rd_start,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2:0]            state,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  wrapped,
  output logic                  bram_we,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  input  logic                  bram_valid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_POST    = 3'd2,
    S_DONE    = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_RD_OUT  = 3'd6
  } st_t;

  st_t st;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] post_lim;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  force_lat;
  logic                  hit;
  logic                  at_last;

  // A force pulse coinciding with a valid sample triggers on that sample.
  assign hit     = trig_in | force_trig | force_lat;
  assign at_last = (wr_ptr == {ADDR_WIDTH{1'b1}});
  assign state   = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= '0;
      post_lim   <= '0;
      remaining  <= '0;
      force_lat  <= 1'b0;
      trig_addr  <= '0;
      wrapped    <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      bram_we    <= 1'b0;
      bram_re    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      bram_we <= 1'b0;
      bram_re <= 1'b0;
      unique case (st)
        S_IDLE, S_DONE: begin
          if (arm) begin
            wr_ptr    <= '0;
            wrapped   <= 1'b0;
            force_lat <= 1'b0;
            trig_addr <= '0;
            // post_len is ADDR_WIDTH wide, so it never exceeds DEPTH-1
            post_lim  <= post_len;
            st        <= S_ARMED;
          end else if (st == S_DONE && rd_start) begin
            // Oldest sample sits at wr_ptr once the ring has wrapped.
            rd_ptr    <= wrapped ? wr_ptr : '0;
            bram_addr <= wrapped ? wr_ptr : '0;
            remaining <= wrapped ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                 : {1'b0, wr_ptr};
            bram_re   <= 1'b1;
            st        <= S_RD_REQ;
          end
        end
        S_ARMED: begin
          if (s_valid) begin
            bram_we    <= 1'b1;
            bram_addr  <= wr_ptr;
            bram_wdata <= s_data;
            wr_ptr     <= wr_ptr + 1'b1;
            if (at_last) wrapped <= 1'b1;
            if (hit) begin
              trig_addr <= wr_ptr;
              post_cnt  <= '0;
              force_lat <= 1'b0;
              st        <= (post_lim == '0) ? S_DONE : S_POST;
            end
          end else if (force_trig) begin
            force_lat <= 1'b1;
          end
        end
        S_POST: begin
          if (s_valid) begin
            bram_we    <= 1'b1;
            bram_addr  <= wr_ptr;
            bram_wdata <= s_data;
            wr_ptr     <= wr_ptr + 1'b1;
            if (at_last) wrapped <= 1'b1;
            post_cnt   <= post_cnt + 1'b1;
            if (post_cnt + 1'b1 == post_lim) st <= S_DONE;
          end
        end
        S_RD_REQ: begin
          // bram_re was raised on entry; the default drops it here.
          st <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (bram_valid) begin
            m_data  <= bram_rdata;
            m_valid <= 1'b1;
            st      <= S_RD_OUT;
          end
        end
        S_RD_OUT: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            rd_ptr    <= rd_ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (ADDR_WIDTH+1)'(1)) begin
              st <= S_IDLE;
            end else begin
              bram_re   <= 1'b1;
              bram_addr <= rd_ptr + 1'b1;
              st        <= S_RD_REQ;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
